// File: rtl/myo_spi_scheduler_if.sv
// SpiControl handshake between the round scheduler (master) and the shared
// SPI frame engine (slave).
interface myo_spi_scheduler_if #(
  parameter int unsigned NUM_MOTORS = 6
);
  logic                  start;
  logic [2:0]            motor_sel;
  logic [NUM_MOTORS-1:0] ss_n_vec;
  logic                  spi_done;

  modport master (
    output start,
    output motor_sel,
    output ss_n_vec,
    input  spi_done
  );

  modport slave (
    input  start,
    input  motor_sel,
    input  ss_n_vec,
    output spi_done
  );
endinterface

// File: rtl/myo_spi_scheduler.sv
// Round-robin scheduler for motor boards sharing one SpiControl: every round
// tick it walks the latched enable mask, running one guarded SPI frame per board.
module myo_spi_scheduler #(
  parameter int unsigned NUM_MOTORS       = 6,
  parameter int unsigned CYCLES_PER_ROUND = 500000,
  parameter int unsigned TIMEOUT_CYCLES   = 5000,
  parameter int unsigned GAP_CYCLES       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_MOTORS-1:0] motor_enable,
  input  logic                  clear_errors,
  myo_spi_scheduler_if.master   spi,
  output logic                  round_done,
  output logic [NUM_MOTORS-1:0] error_mask,
  output logic                  overrun
);

  localparam int unsigned TICK_W  = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1;
  localparam int unsigned CYC_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ACCEPT,
    S_BUSY,
    S_GAP
  } state_e;

  state_e                state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_MOTORS-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_MOTORS-1:0] ss_n_q, ss_n_d;
  logic [NUM_MOTORS-1:0] err_q, err_d;
  logic                  start_q, start_d;
  logic                  round_done_q, round_done_d;
  logic                  ovr_q, ovr_d;

  logic                  tick_c;
  logic [NUM_MOTORS-1:0] remaining_c;
  logic                  none_left_c;
  logic                  found_c;
  logic                  tmo_hit_c;
  logic                  gap_done_c;
  logic                  tmo_evt_c;

  // Free-running round timer
  assign tick_c = (tick_cnt_q == TICK_W'(CYCLES_PER_ROUND - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Bits at or above the search index; empty means the round is finished
  assign remaining_c = mask_q >> idx_q;
  assign none_left_c = (remaining_c == '0);
  assign found_c     = remaining_c[0];
  assign tmo_hit_c   = (cyc_q == CYC_W'(TIMEOUT_CYCLES - 1));
  assign gap_done_c  = (cyc_q == CYC_W'(GAP_CYCLES - 1));
  assign tmo_evt_c   = tmo_hit_c &&
                       (((state_q == S_ACCEPT) &&  spi.spi_done) ||
                        ((state_q == S_BUSY)   && !spi.spi_done));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (tick_c) state_d = S_SELECT;
      S_SELECT: begin
        if (none_left_c)  state_d = S_IDLE;
        else if (found_c) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (!spi.spi_done)  state_d = S_BUSY;
        else if (tmo_hit_c) state_d = S_GAP;
      end
      S_BUSY:   if (spi.spi_done || tmo_hit_c) state_d = S_GAP;
      S_GAP:    if (gap_done_c) state_d = S_SELECT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values; a new error beats clear_errors
  always_comb begin
    mask_d       = mask_q;
    idx_d        = idx_q;
    sel_d        = sel_q;
    cyc_d        = cyc_q + CYC_W'(1);
    round_done_d = 1'b0;
    err_d        = clear_errors ? '0 : err_q;
    ovr_d        = clear_errors ? 1'b0 : ovr_q;
    if (tmo_evt_c) err_d = err_d | (NUM_MOTORS'(1) << sel_q);
    if (tick_c && (state_q != S_IDLE)) ovr_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (tick_c) begin
          mask_d = motor_enable;
          idx_d  = '0;
        end
      end
      S_SELECT: begin
        cyc_d = '0;
        if (none_left_c)  round_done_d = 1'b1;
        else if (found_c) sel_d = SEL_W'(idx_q);
        else              idx_d = idx_q + IDX_W'(1);
      end
      S_ACCEPT, S_BUSY: if (state_d != state_q) cyc_d = '0;
      S_GAP: begin
        if (gap_done_c) begin
          idx_d = idx_q + IDX_W'(1);
          cyc_d = '0;
        end
      end
      default: cyc_d = '0;
    endcase

    start_d = (state_d == S_ACCEPT);
    ss_n_d  = ((state_d == S_ACCEPT) || (state_d == S_BUSY)) ?
              ~(NUM_MOTORS'(1) << sel_d) : '1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q        <= '0;
      idx_q        <= '0;
      mask_q       <= '0;
      sel_q        <= '0;
      ss_n_q       <= '1;
      err_q        <= '0;
      start_q      <= 1'b0;
      round_done_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      sel_q        <= sel_d;
      ss_n_q       <= ss_n_d;
      err_q        <= err_d;
      start_q      <= start_d;
      round_done_q <= round_done_d;
      ovr_q        <= ovr_d;
    end
  end

  assign spi.start     = start_q;
  assign spi.motor_sel = sel_q;
  assign spi.ss_n_vec  = ss_n_q;
  assign round_done    = round_done_q;
  assign error_mask    = err_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Scoreboard bench for myo_spi_scheduler: a round-level model queues the expected
// frame order per accepted tick; a monitor checks frames and round_done pulses.
module tb_myo_spi_scheduler;
  localparam int unsigned NM  = 6;
  localparam int unsigned CPR = 1000;
  localparam int unsigned TMO = 600;
  localparam int unsigned GAP = 16;

  logic          clock;
  logic          reset;
  logic [NM-1:0] motor_enable;
  logic          clear_errors;
  logic          round_done;
  logic [NM-1:0] error_mask;
  logic          overrun;

  myo_spi_scheduler_if #(.NUM_MOTORS(NM)) spi_if ();

  myo_spi_scheduler #(
    .NUM_MOTORS      (NM),
    .CYCLES_PER_ROUND(CPR),
    .TIMEOUT_CYCLES  (TMO),
    .GAP_CYCLES      (GAP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .motor_enable(motor_enable),
    .clear_errors(clear_errors),
    .spi         (spi_if),
    .round_done  (round_done),
    .error_mask  (error_mask),
    .overrun     (overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int            n_checks = 0;
  int            n_fail   = 0;
  int            sbq[$];
  bit            round_active = 1'b0;
  int            e = 0;
  int            tick_e = 0;
  bit            last_zero = 1'b0;
  logic [NM-1:0] exp_err = '0;
  bit            exp_ovr = 1'b0;
  int            hang_board = -1;
  int            frame_lo = 10;
  int            frame_hi = 80;
  int            acc_lat = 2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-level reference: each accepted tick expects the enabled boards in
  // ascending order then one round_done; ticks during a round only raise overrun.
  always @(posedge clock) begin
    if (reset) begin
      e = 0;
    end else begin
      e++;
      if (clear_errors) begin
        exp_err = '0;
        exp_ovr = 1'b0;
      end
      if (e % CPR == 0) begin
        if (round_active) begin
          exp_ovr = 1'b1;
        end else begin
          round_active = 1'b1;
          tick_e       = e;
          last_zero    = (motor_enable == '0);
          for (int i = 0; i < NM; i++) begin
            if (motor_enable[i]) begin
              sbq.push_back(i);
              if (i == hang_board) exp_err[i] = 1'b1;
            end
          end
          sbq.push_back(-1);
        end
      end
    end
  end

  // SpiControl behavioural slave: accept after acc_lat, finish after a random length
  int m_state = 0;
  int m_cnt   = 0;
  always @(negedge clock) begin
    if (reset) begin
      spi_if.spi_done = 1'b1;
      m_state = 0;
    end else begin
      case (m_state)
        0: if (spi_if.start) begin
          m_cnt   = acc_lat;
          m_state = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt <= 0) begin
            spi_if.spi_done = 1'b0;
            if (int'(spi_if.motor_sel) == hang_board) begin
              m_state = 0;
            end else begin
              m_cnt   = $urandom_range(frame_hi, frame_lo);
              m_state = 2;
            end
          end
        end
        default: begin
          m_cnt--;
          if (m_cnt <= 0) begin
            spi_if.spi_done = 1'b1;
            m_state = 0;
          end
        end
      endcase
    end
  end

  // Monitor
  bit prev_start = 1'b0;
  always @(negedge clock) begin
    int            lows;
    int            exp_b;
    logic [NM-1:0] exp_ss;
    if (reset) begin
      prev_start = 1'b0;
    end else begin
      lows = NM - $countones(spi_if.ss_n_vec);
      chk("one_slave_selected", 64'(lows > 1), 0);
      chk("start_with_select", 64'(spi_if.start && (lows != 1)), 0);
      if (spi_if.start && !prev_start) begin
        chk("frame_expected", 64'(sbq.size() > 0 && sbq[0] >= 0), 1);
        if (sbq.size() > 0) begin
          exp_b = sbq.pop_front();
          if (exp_b >= 0) begin
            exp_ss        = '1;
            exp_ss[exp_b] = 1'b0;
            chk("frame_motor_sel", 64'(spi_if.motor_sel), 64'(exp_b));
            chk("frame_ss_n_vec", 64'(spi_if.ss_n_vec), 64'(exp_ss));
          end
        end
      end
      if (round_done) begin
        chk("round_done_expected", 64'(sbq.size() > 0 && sbq[0] == -1), 1);
        if (sbq.size() > 0) void'(sbq.pop_front());
        if (last_zero) chk("zero_round_latency", 64'((e - tick_e) <= 2), 1);
        round_active = 1'b0;
      end
      prev_start = spi_if.start;
    end
  end

  task automatic run_round(input bit rnd);
    int k = 0;
    while (!round_active && k < 3 * CPR) begin
      @(negedge clock);
      if (rnd) motor_enable = NM'($urandom);
      k++;
    end
    chk("round_started", 64'(round_active), 1);
    k = 0;
    while (round_active && k < 8000) begin
      @(negedge clock);
      if (rnd) motor_enable = NM'($urandom);
      k++;
    end
    chk("round_finished", 64'(round_active), 0);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_error_mask"}, 64'(error_mask), 64'(exp_err));
    chk({nm, "_overrun"}, 64'(overrun), 64'(exp_ovr));
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
  endtask

  // Wait until board b's frame has been accepted (start dropped while selected)
  task automatic wait_busy(input int b);
    int k = 0;
    while (!(spi_if.start && int'(spi_if.motor_sel) == b) && k < 4 * CPR) begin
      @(negedge clock);
      k++;
    end
    while (spi_if.start && k < 4 * CPR) begin
      @(negedge clock);
      k++;
    end
    chk("reached_busy", 64'(k < 4 * CPR), 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_start"}, 64'(spi_if.start), 0);
    chk({nm, "_motor_sel"}, 64'(spi_if.motor_sel), 0);
    chk({nm, "_ss_n_vec"}, 64'(spi_if.ss_n_vec), 64'(6'b111111));
    chk({nm, "_round_done"}, 64'(round_done), 0);
    chk({nm, "_error_mask"}, 64'(error_mask), 0);
    chk({nm, "_overrun"}, 64'(overrun), 0);
  endtask

  initial begin
    reset        = 1'b1;
    clear_errors = 1'b0;
    motor_enable = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Sparse mask, well-behaved slave
    motor_enable = 6'b101101;
    run_round(1'b0);
    check_quiet("basic");
    chk("basic_no_errors", 64'(error_mask), 0);

    // Board 3 hangs after accept; board 5 still served
    hang_board = 3;
    run_round(1'b0);
    hang_board = -1;
    chk("hang3_error_mask", 64'(error_mask), 64'(6'b001000));
    check_quiet("hang3");

    // Board 1 times out in the same cycle clear_errors is pulsed
    motor_enable = 6'b000011;
    hang_board   = 1;
    wait_busy(1);
    repeat (TMO - 1) @(negedge clock);
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    run_round(1'b0);
    hang_board = -1;
    exp_err    = 6'b000010;
    chk("clear_vs_timeout", 64'(error_mask), 64'(6'b000010));
    check_quiet("clear_vs_timeout");
    pulse_clear();
    @(negedge clock);
    check_quiet("cleared");

    // Long frames on all boards overrun the round period
    frame_lo     = 400;
    frame_hi     = 400;
    motor_enable = 6'b111111;
    run_round(1'b0);
    frame_lo = 10;
    frame_hi = 80;
    chk("overrun_set", 64'(overrun), 1);
    check_quiet("overrun");
    pulse_clear();
    @(negedge clock);
    chk("overrun_cleared", 64'(overrun), 0);

    // Empty mask: no frames, one round_done per tick
    motor_enable = '0;
    run_round(1'b0);
    run_round(1'b0);
    check_quiet("zero_mask");

    // Reset in the middle of board 2's frame
    motor_enable = 6'b111111;
    wait_busy(2);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    sbq.delete();
    round_active = 1'b0;
    exp_err      = '0;
    exp_ovr      = 1'b0;
    #1 check_reset_outputs("mid_frame_reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    run_round(1'b0);
    check_quiet("after_reset");

    // Random masks changing every cycle; only the tick-time value counts
    frame_hi = 120;
    for (int r = 0; r < 10; r++) run_round(1'b1);
    check_quiet("random");

    repeat (10) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
